uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Controller that shares the single UART transmit path between `N_REQ` byte requesters and reprograms the baud setting of the UART clock generator. Arbitrates requesters round-robin and issues one-cycle start pulses to the transmitter. Tracks the transmitter's busy flag. Serialises baud-rate changes so the clock generator is only reconfigured while the line is idle, then holds off traffic for a settle window.

## Interface
Parameters:
- `N_REQ`, 4, number of byte requesters (2..8)
- `SETTLE_CYCLES`, 32, idle cycles after a baud change before traffic resumes (≥1)
- `ACK_TIMEOUT`, 1024, max cycles from `tx_start_o` to `tx_busy_i` rising (≥2)

Ports:
- `clk_i`, in, 1, single clock
- `rst_i`, in, 1, synchronous, active-high reset
- `req_valid_i`, in, N_REQ, per-requester byte valid
- `req_data_i`, in, 8*N_REQ, requester k's byte at [8k+7:8k]
- `req_ready_o`, out, N_REQ, one-hot accept strobe
- `baud_req_valid_i`, in, 1, baud change request
- `baud_req_i`, in, 17, requested baud rate in bits/s
- `baud_req_ready_o`, out, 1, baud request accepted this cycle
- `baud_o`, out, 17, baud setting driven to clock generator
- `tx_start_o`, out, 1, one-cycle transmit start pulse
- `tx_data_o`, out, 8, byte for the transmitter, stable from accept until the next accept
- `tx_busy_i`, in, 1, transmitter busy
- `grant_id_o`, out, $clog2(N_REQ), index of last granted requester
- `cfg_err_o`, out, 1, one-cycle pulse: unsupported baud rejected
- `tx_err_o`, out, 1, one-cycle pulse: ack timeout

## Operation
- The controller has five states:
  - IDLE
  - LAUNCH
  - WAIT_ACK
  - WAIT_DONE
  - SETTLE
- IDLE, baud first:
  - When `baud_req_valid_i`=1, `baud_req_ready_o`=1 and the request is accepted.
  - A supported rate is one of 4800, 9600, 14400, 19200, 38400, 57600, 115200 or 128000. It is latched into `baud_o` next cycle and the state goes to SETTLE.
  - An unsupported rate pulses `cfg_err_o` next cycle, leaves `baud_o` unchanged and keeps the state in IDLE.
  - No data accept happens in that cycle.
- IDLE, data (only when no baud request is pending):
  - Round-robin picks the first valid requester scanning from `grant_id_o`+1 (mod N_REQ).
  - `req_ready_o[g]`=1 combinationally in the same cycle.
  - `req_data_i[g]` is captured into `tx_data_o`, `grant_id_o`←g, and the state goes to LAUNCH.
- LAUNCH: `tx_start_o`=1 for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK:
  - `tx_busy_i`=1 → WAIT_DONE.
  - After ACK_TIMEOUT cycles with no busy, pulse `tx_err_o` and return to IDLE. The byte is dropped, not retried.
- WAIT_DONE: `tx_busy_i`=0 → IDLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to IDLE. All ready outputs are 0.
- `req_ready_o` and `baud_req_ready_o` are 0 outside IDLE. Requesters must hold valid and data until ready.
- Reset values:
  - state IDLE
  - `baud_o`=9600
  - `grant_id_o`=N_REQ-1, so requester 0 wins first
  - `tx_data_o`=0
  - all strobes 0
  - counters 0
- Reset mid-transfer returns to IDLE with no start or error pulse. The transmitter is reset by the same `rst_i`.

## Timing
- Byte accepted at cycle T → `tx_start_o` at T+1 → next accept at the earliest one cycle after `tx_busy_i` falls.
- A baud accept at T gives `baud_o` valid at T+1 and the next accept at T+1+SETTLE_CYCLES.
- The WAIT_ACK counter starts at 0 in the first WAIT_ACK cycle. Timeout fires when the count reaches ACK_TIMEOUT-1 with busy still low.
- Busy rising in the same cycle as the timeout takes priority: go to WAIT_DONE, no error.
- The round-robin pointer wraps N_REQ-1 → 0. A single persistent requester is granted back-to-back.

## Structure
- Shared `uart_pkg` holds:
  - the state enum
  - the supported-baud localparams
  - a `baud_supported()` function
  - the default baud 9600, also used by the clock generator's default case
- Sub-module `rr_arbiter` (parameter N): inputs request vector and pointer; outputs the one-hot grant and the grant index. It is purely combinational and is instantiated once.

## Test plan
- Reset, then requesters 0 and 2 valid with 0x55 and 0xA3, and the transmitter model busy for 20 cycles after each start. Expect 0x55 sent, then 0xA3, with `grant_id_o` 0 then 2.
- All four requesters valid continuously for 8 bytes. Expect grant order 0,1,2,3,0,1,2,3, with exactly one `req_ready_o` bit per accept.
- `baud_req_i`=115200 while a byte is in flight:
  - not accepted until IDLE
  - `baud_o`=115200 the cycle after accept
  - no data accept for 32 cycles
- `baud_req_i`=12345. Expect `cfg_err_o` to pulse once and `baud_o` to stay 9600.
- Transmitter model never raises busy. Expect `tx_err_o` at start+1024 and the next requester then granted.
- Assert `rst_i` during WAIT_DONE. Expect all outputs at reset values the next cycle and `baud_o`=9600.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: controller states,
// supported baud rates and the rate-check helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_SETTLE    = 3'd4
  } state_e;

  localparam int BAUD_W = 17;

  localparam logic [BAUD_W-1:0] BAUD_4800   = 17'd4800;
  localparam logic [BAUD_W-1:0] BAUD_9600   = 17'd9600;
  localparam logic [BAUD_W-1:0] BAUD_14400  = 17'd14400;
  localparam logic [BAUD_W-1:0] BAUD_19200  = 17'd19200;
  localparam logic [BAUD_W-1:0] BAUD_38400  = 17'd38400;
  localparam logic [BAUD_W-1:0] BAUD_57600  = 17'd57600;
  localparam logic [BAUD_W-1:0] BAUD_115200 = 17'd115200;
  localparam logic [BAUD_W-1:0] BAUD_128000 = 17'd128000;

  // Also the clock generator's fallback for unknown settings.
  localparam logic [BAUD_W-1:0] BAUD_DEFAULT = BAUD_9600;

  function automatic logic baud_supported(input logic [BAUD_W-1:0] rate);
    case (rate)
      BAUD_4800, BAUD_9600, BAUD_14400, BAUD_19200,
      BAUD_38400, BAUD_57600, BAUD_115200, BAUD_128000: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request scanning upward
// from the slot after ptr_i, wrapping at N-1.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int IW = $clog2(N);

  always_comb begin
    logic [IW-1:0] k;
    logic          found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(ptr_i) + i) % N);
      if (!found && req_i[k]) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = k;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among N_REQ byte requesters and applies baud
// changes only while the line is idle, followed by a settle window.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int SETTLE_CYCLES = 32,
  parameter int ACK_TIMEOUT   = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [8*N_REQ-1:0]       req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic                     baud_req_valid_i,
  input  logic [16:0]              baud_req_i,
  output logic                     baud_req_ready_o,
  output logic [16:0]              baud_o,
  output logic                     tx_start_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_busy_i,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     cfg_err_o,
  output logic                     tx_err_o,
  output logic [2:0]               state_o
);

  // Handshake: a transfer occurs in any cycle where valid and ready are both
  // high. Ready is raised combinationally, only in IDLE; requesters hold valid
  // and data stable until they see ready.

  localparam int IW   = $clog2(N_REQ);
  localparam int CMAX = (ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] ACK_LAST    = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [16:0]     baud_q, baud_d;
  logic [7:0]      data_q, data_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cfg_err_q, cfg_err_d;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (grant_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  assign arb_any = |arb_grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      baud_q    <= BAUD_DEFAULT;
      data_q    <= '0;
      grant_q   <= IW'(N_REQ - 1);
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      data_q    <= data_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    baud_d           = baud_q;
    data_d           = data_q;
    grant_d          = grant_q;
    cnt_d            = cnt_q;
    cfg_err_d        = 1'b0;
    req_ready_o      = '0;
    baud_req_ready_o = 1'b0;
    tx_start_o       = 1'b0;
    tx_err_o         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A pending baud request blocks data accepts for this cycle.
        if (baud_req_valid_i) begin
          baud_req_ready_o = 1'b1;
          if (baud_supported(baud_req_i)) begin
            baud_d  = baud_req_i;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else if (arb_any) begin
          req_ready_o = arb_grant;
          data_d      = req_data_i[{arb_idx, 3'b000} +: 8];
          grant_d     = arb_idx;
          state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tx_start_o = 1'b1;
        cnt_d      = '0;
        state_d    = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // Busy wins over a timeout landing in the same cycle.
        if (tx_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == ACK_LAST) begin
          tx_err_o = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) state_d = ST_IDLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_IDLE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign baud_o     = baud_q;
  assign tx_data_o  = data_q;
  assign grant_id_o = grant_q;
  assign cfg_err_o  = cfg_err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queued requesters, a transmitter responder with
// programmable ack delay/busy length, and a round-robin order model.
module tb_uart_tx_sched;

  localparam int N      = 4;
  localparam int SETTLE = 32;
  localparam int ACK_TO = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           baud_req_valid = 1'b0;
  logic [16:0]    baud_req = '0;
  logic           baud_req_ready;
  logic [16:0]    baud;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           cfg_err;
  logic           tx_err;
  logic [2:0]     state_dbg;

  uart_tx_sched #(.N_REQ(N), .SETTLE_CYCLES(SETTLE), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid),
    .req_data_i       (req_data),
    .req_ready_o      (req_ready),
    .baud_req_valid_i (baud_req_valid),
    .baud_req_i       (baud_req),
    .baud_req_ready_o (baud_req_ready),
    .baud_o           (baud),
    .tx_start_o       (tx_start),
    .tx_data_o        (tx_data),
    .tx_busy_i        (tx_busy),
    .grant_id_o       (grant_id),
    .cfg_err_o        (cfg_err),
    .tx_err_o         (tx_err),
    .state_o          (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- requester / responder drivers ----------------
  logic [7:0] req_q [N][$];
  logic [7:0] mdl_q [N][$];
  int tx_delay = 1;
  int busy_len = 20;

  initial forever begin
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      req_valid[k]       = (req_q[k].size() > 0);
      req_data[8*k +: 8] = (req_q[k].size() > 0) ? req_q[k][0] : 8'h00;
    end
  end

  // Busy rises tx_delay cycles after a start (0 = never) and lasts busy_len cycles.
  initial begin
    int dly;
    int left;
    logic st;
    dly = 0; left = 0;
    forever begin
      @(negedge clk); st = tx_start;
      @(posedge clk); #1;
      if (rst_i) begin
        dly = 0; left = 0; tx_busy = 1'b0;
      end else begin
        if (st && tx_delay > 0) dly = tx_delay;
        if (dly > 0) begin
          dly--;
          if (dly == 0) left = busy_len;
        end
        if (left > 0) begin tx_busy = 1'b1; left--; end
        else tx_busy = 1'b0;
      end
    end
  end

  // ---------------- monitor logs ----------------
  int acc_cyc_q[$], acc_idx_q[$];
  int st_cyc_q[$], st_gid_q[$];
  logic [7:0] st_data_q[$];
  int err_cyc_q[$], cfg_cyc_q[$], bacc_cyc_q[$];
  int onehot_bad = 0;

  initial begin
    logic [7:0] tmp;
    forever begin
      @(negedge clk);
      if (req_ready != '0) begin
        if (!$onehot(req_ready)) onehot_bad++;
        for (int k = 0; k < N; k++) if (req_ready[k]) begin
          acc_cyc_q.push_back(cyc);
          acc_idx_q.push_back(k);
          if (req_q[k].size() > 0) tmp = req_q[k].pop_front();
        end
      end
      if (tx_start) begin
        st_cyc_q.push_back(cyc);
        st_data_q.push_back(tx_data);
        st_gid_q.push_back(int'(grant_id));
      end
      if (tx_err) err_cyc_q.push_back(cyc);
      if (cfg_err) cfg_cyc_q.push_back(cyc);
      if (baud_req_ready) bacc_cyc_q.push_back(cyc);
    end
  end

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] exp_q[$];
  int exp_idx_q[$];
  int model_ptr = N - 1;

  task automatic load(input int k, input logic [7:0] b);
    req_q[k].push_back(b);
    mdl_q[k].push_back(b);
  endtask

  // Round-robin rule: first non-empty requester after the last grant, wrapping.
  task automatic build_expect();
    int pick;
    int k;
    exp_q.delete();
    exp_idx_q.delete();
    while (1) begin
      pick = -1;
      for (int i = 1; i <= N; i++) begin
        k = (model_ptr + i) % N;
        if (pick < 0 && mdl_q[k].size() > 0) pick = k;
      end
      if (pick < 0) break;
      exp_idx_q.push_back(pick);
      exp_q.push_back(mdl_q[pick].pop_front());
      model_ptr = pick;
    end
  endtask

  function automatic bit is_std(input int r);
    int rates[8] = '{4800, 9600, 14400, 19200, 38400, 57600, 115200, 128000};
    foreach (rates[i]) if (rates[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_pending();
    for (int k = 0; k < N; k++) if (req_q[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_logs();
    acc_cyc_q.delete(); acc_idx_q.delete();
    st_cyc_q.delete(); st_gid_q.delete(); st_data_q.delete();
    err_cyc_q.delete(); cfg_cyc_q.delete(); bacc_cyc_q.delete();
    onehot_bad = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1;
    baud_req_valid = 1'b0;
    for (int k = 0; k < N; k++) begin req_q[k].delete(); mdl_q[k].delete(); end
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    model_ptr = N - 1;
    clear_logs();
  endtask

  task automatic wait_drain(input int tail, input string name);
    int n;
    n = 0;
    while (any_pending() && n < 4000) begin @(posedge clk); #2; n++; end
    checks++;
    if (any_pending()) begin
      errors++;
      $display("FAIL %s_drain: bytes still pending after %0d cycles, expected none", name, n);
    end
    repeat (tail) @(posedge clk);
    #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (baud !== 17'd9600) begin errors++; $display("FAIL reset_baud: got %0d expected 9600", baud); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL reset_grant: got %0d expected 3", grant_id); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %0h expected 0", tx_data); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset_tx_err: got %b expected 0", tx_err); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (baud_req_ready !== 1'b0) begin errors++; $display("FAIL reset_baud_ready: got %b expected 0", baud_req_ready); end
  endtask

  task automatic test_two_req();
    clear_logs();
    tx_delay = 1; busy_len = 20;
    load(0, 8'h55);
    load(2, 8'hA3);
    build_expect();
    wait_drain(busy_len + 8, "two_req");
    checks++; if (acc_idx_q.size() != 2 || st_data_q.size() != 2) begin
      errors++; $display("FAIL two_req_count: got %0d accepts %0d starts expected 2 and 2", acc_idx_q.size(), st_data_q.size());
    end
    for (int i = 0; i < 2 && i < acc_idx_q.size() && i < st_data_q.size(); i++) begin
      checks++; if (acc_idx_q[i] != exp_idx_q[i]) begin errors++; $display("FAIL two_req_idx%0d: got %0d expected %0d", i, acc_idx_q[i], exp_idx_q[i]); end
      checks++; if (st_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL two_req_data%0d: got %0h expected %0h", i, st_data_q[i], exp_q[i]); end
      checks++; if (st_gid_q[i] != exp_idx_q[i]) begin errors++; $display("FAIL two_req_gid%0d: got %0d expected %0d", i, st_gid_q[i], exp_idx_q[i]); end
      checks++; if (st_cyc_q[i] != acc_cyc_q[i] + 1) begin errors++; $display("FAIL two_req_start%0d: got cycle %0d expected %0d", i, st_cyc_q[i], acc_cyc_q[i] + 1); end
    end
    if (acc_cyc_q.size() == 2) begin
      checks++; if (acc_cyc_q[1] - acc_cyc_q[0] != tx_delay + busy_len + 2) begin
        errors++; $display("FAIL two_req_gap: got %0d expected %0d", acc_cyc_q[1] - acc_cyc_q[0], tx_delay + busy_len + 2);
      end
    end
  endtask

  task automatic test_round_robin();
    int cnt;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      clear_logs();
      tx_delay = 1;
      busy_len = $urandom_range(1, 10);
      for (int k = 0; k < N; k++) begin
        cnt = (r == 0) ? 2 : $urandom_range(0, 3);
        for (int j = 0; j < cnt; j++) load(k, 8'($urandom));
      end
      build_expect();
      wait_drain(busy_len + 8, "rr");
      checks++; if (acc_idx_q.size() != exp_idx_q.size() || st_data_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rr%0d_count: got %0d accepts %0d starts expected %0d", r, acc_idx_q.size(), st_data_q.size(), exp_q.size());
      end
      checks++; if (onehot_bad != 0) begin errors++; $display("FAIL rr%0d_onehot: got %0d bad ready cycles expected 0", r, onehot_bad); end
      for (int i = 0; i < exp_q.size() && i < acc_idx_q.size() && i < st_data_q.size(); i++) begin
        checks++; if (acc_idx_q[i] != exp_idx_q[i]) begin errors++; $display("FAIL rr%0d_idx%0d: got %0d expected %0d", r, i, acc_idx_q[i], exp_idx_q[i]); end
        checks++; if (st_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr%0d_data%0d: got %0h expected %0h", r, i, st_data_q[i], exp_q[i]); end
        if (i > 0) begin
          checks++; if (acc_cyc_q[i] - acc_cyc_q[i-1] != tx_delay + busy_len + 2) begin
            errors++; $display("FAIL rr%0d_gap%0d: got %0d expected %0d", r, i, acc_cyc_q[i] - acc_cyc_q[i-1], tx_delay + busy_len + 2);
          end
        end
      end
    end
  endtask

  task automatic test_baud_bad();
    logic [16:0] rate;
    clear_logs();
    for (int v = 0; v < 4; v++) begin
      if (v == 0) rate = 17'd12345;
      else begin
        rate = 17'($urandom_range(0, 131071));
        while (is_std(int'(rate))) rate = 17'($urandom_range(0, 131071));
      end
      @(posedge clk); #1;
      baud_req_valid = 1'b1; baud_req = rate;
      @(negedge clk);
      checks++; if (baud_req_ready !== 1'b1) begin errors++; $display("FAIL bad%0d_ready: got %b expected 1", v, baud_req_ready); end
      @(posedge clk); #1;
      baud_req_valid = 1'b0;
      @(negedge clk);
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL bad%0d_cfg_err: got %b expected 1", v, cfg_err); end
      checks++; if (baud !== 17'd9600) begin errors++; $display("FAIL bad%0d_baud: got %0d expected 9600", v, baud); end
      @(negedge clk);
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL bad%0d_cfg_err_pulse: got %b expected 0", v, cfg_err); end
    end
    checks++; if (cfg_cyc_q.size() != 4) begin errors++; $display("FAIL bad_cfg_count: got %0d expected 4", cfg_cyc_q.size()); end
  endtask

  task automatic test_baud_in_flight();
    int n, s, tb_acc;
    logic [7:0] first_b;
    clear_logs();
    tx_delay = 1; busy_len = 20;
    load(1, 8'($urandom));
    build_expect();
    first_b = exp_q[0];
    n = 0;
    while (st_cyc_q.size() == 0 && n < 200) begin @(posedge clk); #2; n++; end
    checks++; if (st_cyc_q.size() == 0) begin errors++; $display("FAIL flight_start: got no start in %0d cycles expected one", n); return; end
    s = st_cyc_q[0];
    baud_req_valid = 1'b1; baud_req = 17'd115200;
    load(2, 8'($urandom));
    build_expect();
    @(negedge clk);
    checks++; if (baud !== 17'd9600) begin errors++; $display("FAIL flight_baud_old: got %0d expected 9600", baud); end
    n = 0;
    while (bacc_cyc_q.size() == 0 && n < 200) begin @(posedge clk); #2; n++; end
    baud_req_valid = 1'b0;
    checks++; if (bacc_cyc_q.size() == 0) begin errors++; $display("FAIL flight_baud_acc: got no accept in %0d cycles expected one", n); return; end
    tb_acc = bacc_cyc_q[0];
    checks++; if (tb_acc != s + tx_delay + busy_len + 1) begin errors++; $display("FAIL flight_baud_acc_cyc: got %0d expected %0d", tb_acc, s + tx_delay + busy_len + 1); end
    @(negedge clk);
    checks++; if (baud !== 17'd115200) begin errors++; $display("FAIL flight_baud_new: got %0d expected 115200", baud); end
    wait_drain(busy_len + 8, "flight");
    checks++; if (acc_cyc_q.size() != 2 || st_data_q.size() != 2) begin
      errors++; $display("FAIL flight_count: got %0d accepts %0d starts expected 2 and 2", acc_cyc_q.size(), st_data_q.size());
    end else begin
      checks++; if (st_data_q[0] !== first_b) begin errors++; $display("FAIL flight_data0: got %0h expected %0h", st_data_q[0], first_b); end
      checks++; if (acc_idx_q[1] != exp_idx_q[0]) begin errors++; $display("FAIL flight_idx1: got %0d expected %0d", acc_idx_q[1], exp_idx_q[0]); end
      checks++; if (st_data_q[1] !== exp_q[0]) begin errors++; $display("FAIL flight_data1: got %0h expected %0h", st_data_q[1], exp_q[0]); end
      checks++; if (acc_cyc_q[1] != tb_acc + 1 + SETTLE) begin errors++; $display("FAIL flight_settle: got accept at %0d expected %0d", acc_cyc_q[1], tb_acc + 1 + SETTLE); end
    end
  endtask

  task automatic test_timeout();
    int n;
    clear_logs();
    tx_delay = 0; busy_len = 20;
    load(0, 8'($urandom));
    load(1, 8'($urandom));
    build_expect();
    n = 0;
    while (err_cyc_q.size() < 2 && n < 3000) begin @(posedge clk); #2; n++; end
    repeat (3) @(posedge clk);
    #2;
    checks++; if (err_cyc_q.size() != 2 || st_cyc_q.size() != 2 || acc_idx_q.size() != 2) begin
      errors++; $display("FAIL to_count: got %0d errs %0d starts %0d accepts expected 2 each", err_cyc_q.size(), st_cyc_q.size(), acc_idx_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (err_cyc_q[i] != st_cyc_q[i] + ACK_TO) begin errors++; $display("FAIL to_err%0d_cyc: got %0d expected %0d", i, err_cyc_q[i], st_cyc_q[i] + ACK_TO); end
        checks++; if (acc_idx_q[i] != exp_idx_q[i]) begin errors++; $display("FAIL to_idx%0d: got %0d expected %0d", i, acc_idx_q[i], exp_idx_q[i]); end
        checks++; if (st_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL to_data%0d: got %0h expected %0h", i, st_data_q[i], exp_q[i]); end
      end
      checks++; if (acc_cyc_q[1] != err_cyc_q[0] + 1) begin errors++; $display("FAIL to_next_acc: got %0d expected %0d", acc_cyc_q[1], err_cyc_q[0] + 1); end
    end
    // Busy arrives in exactly the timeout cycle: must complete without error.
    clear_logs();
    tx_delay = ACK_TO; busy_len = 5;
    load(3, 8'($urandom));
    load(0, 8'($urandom));
    build_expect();
    wait_drain(ACK_TO + busy_len + 8, "to_edge");
    checks++; if (err_cyc_q.size() != 0) begin errors++; $display("FAIL to_edge_err: got %0d errors expected 0", err_cyc_q.size()); end
    checks++; if (acc_idx_q.size() != 2 || st_cyc_q.size() != 2) begin
      errors++; $display("FAIL to_edge_count: got %0d accepts %0d starts expected 2 and 2", acc_idx_q.size(), st_cyc_q.size());
    end else begin
      checks++; if (acc_idx_q[0] != exp_idx_q[0] || acc_idx_q[1] != exp_idx_q[1]) begin
        errors++; $display("FAIL to_edge_order: got %0d,%0d expected %0d,%0d", acc_idx_q[0], acc_idx_q[1], exp_idx_q[0], exp_idx_q[1]);
      end
      checks++; if (acc_cyc_q[1] != st_cyc_q[0] + tx_delay + busy_len + 1) begin
        errors++; $display("FAIL to_edge_next: got %0d expected %0d", acc_cyc_q[1], st_cyc_q[0] + tx_delay + busy_len + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_logs();
    tx_delay = 1; busy_len = 20;
    load(2, 8'($urandom_range(1, 255)));
    build_expect();
    n = 0;
    while (st_cyc_q.size() == 0 && n < 200) begin @(posedge clk); #2; n++; end
    checks++; if (st_cyc_q.size() == 0) begin errors++; $display("FAIL mid_start: got no start in %0d cycles expected one", n); end
    repeat (5) @(posedge clk);
    #1;
    rst_i = 1'b1;
    for (int k = 0; k < N; k++) begin req_q[k].delete(); mdl_q[k].delete(); end
    clear_logs();
    @(negedge clk);
    @(negedge clk);
    checks++; if (baud !== 17'd9600) begin errors++; $display("FAIL mid_baud: got %0d expected 9600", baud); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL mid_grant: got %0d expected 3", grant_id); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data: got %0h expected 0", tx_data); end
    checks++; if ({tx_start, tx_err, cfg_err, baud_req_ready} !== 4'b0000) begin
      errors++; $display("FAIL mid_strobes: got %b expected 0000", {tx_start, tx_err, cfg_err, baud_req_ready});
    end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL mid_req_ready: got %b expected 0000", req_ready); end
    @(posedge clk); #1;
    rst_i = 1'b0;
    model_ptr = N - 1;
    repeat (40) @(posedge clk);
    #2;
    checks++; if (st_cyc_q.size() != 0 || err_cyc_q.size() != 0) begin
      errors++; $display("FAIL mid_pulses: got %0d starts %0d errors expected 0 and 0", st_cyc_q.size(), err_cyc_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_round_robin();
    test_baud_bad();
    test_baud_in_flight();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    checks++; errors++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
